// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch state encoding and
// instruction-word constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests one word per instruction and
// holds it for the decoder until acknowledged.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        instr_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instret
);

  fetch_state_e r_state;
  logic [31:0]  r_fetch_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc;
  logic [31:0]  r_instret;
  logic         r_instr_valid;
  logic         r_imem_req;
  logic [31:0]  w_next_addr;

  // Next-PC mux; only consumed on an acknowledge in HOLD.
  assign w_next_addr = redirect ? align_word(redirect_target) : (r_pc + INSTR_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_fetch_addr  <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_pc          <= RESET_PC;
      r_instret     <= 32'd0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            r_instr       <= imem_rdata;
            r_pc          <= r_fetch_addr;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            r_fetch_addr  <= w_next_addr;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_instret     <= r_instret + 32'd1;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_instr       <= NOP_INSTR;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end
      endcase
    end
  end

  // Every output comes straight from a register.
  assign imem_addr   = r_fetch_addr;
  assign imem_req    = r_imem_req;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign instret     = r_instret;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small memory model supplies words and a
// scoreboard queue carries the expected instr/pc of each issued response.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        instr_ack;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instret;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    if (a == 32'h0000_0200) return 32'h0000_0000;
    return {a[15:0], 16'h0013};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .instr_ack       (instr_ack),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instret         (instret)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_instret = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},     {31'd0, imem_req},    32'd0);
    chk({tag, "_addr"},    imem_addr,            32'h0000_0100);
    chk({tag, "_instr"},   instr,                32'h0);
    chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
    chk({tag, "_pc"},      pc,                   32'h0000_0100);
    chk({tag, "_instret"}, instret,              32'd0);
  endtask

  // Current cycle must be FETCH at exp_addr; memory answers this cycle.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr);
    exp_t e;
    chk({tag, "_req"},  {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    imem_ready = 1'b1;
    sb.push_back('{word: mem_word(exp_addr), addr: exp_addr});
    tick();
    imem_ready = 1'b0;
    e = sb.pop_front();
    chk({tag, "_instr"}, instr, e.word);
    chk({tag, "_pc"},    pc, e.addr);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_reqlo"}, {31'd0, imem_req}, 32'd0);
  endtask

  // Current cycle must be HOLD; acknowledge and check the following FETCH.
  task automatic do_ack(input string tag, input logic redir, input logic [31:0] tgt,
                        input logic [31:0] exp_next);
    instr_ack       = 1'b1;
    redirect        = redir;
    redirect_target = tgt;
    tick();
    instr_ack = 1'b0;
    redirect  = 1'b0;
    exp_instret = exp_instret + 32'd1;
    chk({tag, "_instret"}, instret, exp_instret);
    chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"},   instr, 32'h0);
    chk({tag, "_req"},     {31'd0, imem_req}, 32'd1);
    chk({tag, "_next"},    imem_addr, exp_next);
  endtask

  task automatic hold_stable(input string tag, input int n, input logic [31:0] exp_instr,
                             input logic [31:0] exp_pc, input logic redir);
    for (int i = 0; i < n; i++) begin
      redirect        = redir;
      redirect_target = 32'h0000_0203;
      tick();
      chk({tag, "_instr"},   instr, exp_instr);
      chk({tag, "_pc"},      pc, exp_pc);
      chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd1);
      chk({tag, "_req"},     {31'd0, imem_req}, 32'd0);
      chk({tag, "_instret"}, instret, exp_instret);
    end
    redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    imem_ready      = 1'b0;
    instr_ack       = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    tick();
    tick();
    chk_reset_values("rst");

    // Cycle 1 after reset: IDLE, memory already ready but must be ignored.
    reset      = 1'b0;
    imem_ready = 1'b1;
    tick();
    chk("boot_novalid", {31'd0, instr_valid}, 32'd0);
    do_fetch("boot", 32'h0000_0100);

    // Sequential fetches, one instruction every two cycles.
    do_ack("seq0", 1'b0, 32'h0, 32'h0000_0104);
    do_fetch("seq1", 32'h0000_0104);
    do_ack("seq1", 1'b0, 32'h0, 32'h0000_0108);
    do_fetch("seq2", 32'h0000_0108);
    do_ack("seq2", 1'b0, 32'h0, 32'h0000_010C);
    chk("instret3", instret, 32'd3);

    // Three wait states: address held, nothing valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr",  imem_addr, 32'h0000_010C);
      chk("wait_req",   {31'd0, imem_req}, 32'd1);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_instr", instr, 32'h0);
    end
    do_fetch("wait", 32'h0000_010C);

    // Redirect without ack is ignored, then a taken redirect to an unaligned target.
    hold_stable("rdnoack", 2, mem_word(32'h0000_010C), 32'h0000_010C, 1'b1);
    do_ack("redir", 1'b1, 32'h0000_0203, 32'h0000_0200);
    do_fetch("zero", 32'h0000_0200);
    do_ack("zero", 1'b0, 32'h0, 32'h0000_0204);

    // Ten-cycle stall, then jump to the top of memory and wrap.
    do_fetch("stall", 32'h0000_0204);
    hold_stable("stall", 10, mem_word(32'h0000_0204), 32'h0000_0204, 1'b0);
    do_ack("jtop", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    do_fetch("top", 32'hFFFF_FFFC);
    do_ack("wrap", 1'b0, 32'h0, 32'h0000_0000);

    // Ack while in FETCH is ignored.
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    chk("fack_instret", instret, exp_instret);
    chk("fack_addr",    imem_addr, 32'h0000_0000);
    chk("fack_valid",   {31'd0, instr_valid}, 32'd0);

    // Reset during FETCH with a response present.
    imem_ready = 1'b1;
    reset      = 1'b1;
    tick();
    imem_ready = 1'b0;
    reset      = 1'b0;
    exp_instret = 32'd0;
    chk_reset_values("rstf");
    tick();
    do_fetch("reboot", 32'h0000_0100);

    // Reset during HOLD with an acknowledge present.
    instr_ack = 1'b1;
    reset     = 1'b1;
    tick();
    instr_ack = 1'b0;
    reset     = 1'b0;
    chk_reset_values("rsth");
    tick();
    do_fetch("reboot2", 32'h0000_0100);
    do_ack("reboot2", 1'b0, 32'h0, 32'h0000_0104);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
